// File: rtl/nn_data_fetcher.sv
// Responder for the NN core's image/coefficient requests: fetches the block from SDRAM over an
// Avalon-MM pipelined read master. Optional checksum outputs are enabled by NN_FETCH_CHECKSUM_EN.
module nn_data_fetcher #(
    parameter int          IMSIZE     = 64,
    parameter int          CSIZE      = 2048,
    parameter int          LBITS      = 2,
    parameter logic [31:0] IMAGE_BASE = 32'h0000_0000,
    parameter logic [31:0] COEFF_BASE = 32'h0001_0000,
    parameter int          MAX_PEND   = 4
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    get_image,
    input  logic                    get_coeffs,
    input  logic [LBITS-1:0]        layer,
    output logic                    busy,
    output logic [IMSIZE-1:0][7:0]  image_data,
    output logic [CSIZE-1:0][7:0]   coeff_data,
    output logic [31:0]             avm_address,
    output logic                    avm_read,
    input  logic                    avm_waitrequest,
    input  logic [31:0]             avm_readdata,
    input  logic                    avm_readdatavalid,
`ifdef NN_FETCH_CHECKSUM_EN
    output logic [15:0]             checksum,
    output logic                    checksum_valid,
`endif
    output logic [1:0]              fsm_state
);
    localparam int IM_WORDS  = IMSIZE / 4;
    localparam int CO_WORDS  = CSIZE / 4;
    localparam int MAX_WORDS = (IM_WORDS > CO_WORDS) ? IM_WORDS : CO_WORDS;
    localparam int CW        = $clog2(MAX_WORDS + 1);
    localparam int IW        = $clog2(IMSIZE);
    localparam int KW        = $clog2(CSIZE);

    localparam logic [1:0]    IDLE     = 2'd0;
    localparam logic [1:0]    ISSUE    = 2'd1;
    localparam logic [1:0]    DRAIN    = 2'd2;
    localparam logic [CW-1:0] IM_N     = CW'(IM_WORDS);
    localparam logic [CW-1:0] CO_N     = CW'(CO_WORDS);
    localparam logic [3:0]    PEND_MAX = 4'(MAX_PEND);

    logic [1:0]    state, state_nxt;
    logic          target, target_nxt;  // 0 = image, 1 = coefficients
    logic [CW-1:0] n_words, n_words_nxt;
    logic [CW-1:0] issued, issued_nxt;
    logic [CW-1:0] returned, returned_nxt;
    logic [31:0]   base, base_nxt, addr_nxt;
    logic [3:0]    pend, pend_nxt;
    logic          read_nxt, accept, rvalid, done;
    logic [IW-1:0] im_idx;
    logic [KW-1:0] co_idx;

    // Handshake: a read transfers when avm_read=1 and avm_waitrequest=0 in the same cycle;
    // while stalled, avm_read/avm_address hold. Each avm_readdatavalid returns one word in order.
    assign accept    = avm_read & ~avm_waitrequest;
    assign rvalid    = avm_readdatavalid & (state != IDLE);
    assign done      = rvalid & ((returned + CW'(1)) == n_words);
    assign im_idx    = IW'({returned, 2'b00});
    assign co_idx    = KW'({returned, 2'b00});
    assign fsm_state = state;

    always_comb begin
        state_nxt    = state;
        target_nxt   = target;
        n_words_nxt  = n_words;
        base_nxt     = base;
        issued_nxt   = accept ? issued + CW'(1) : issued;
        returned_nxt = rvalid ? returned + CW'(1) : returned;
        pend_nxt     = pend;
        if (accept && !rvalid)
            pend_nxt = pend + 4'd1;
        else if (!accept && rvalid)
            pend_nxt = pend - 4'd1;

        case (state)
            IDLE: begin
                issued_nxt   = '0;
                returned_nxt = '0;
                pend_nxt     = '0;
                // Image wins a tie; a simultaneous coefficient request is dropped.
                if (get_image) begin
                    target_nxt  = 1'b0;
                    n_words_nxt = IM_N;
                    base_nxt    = IMAGE_BASE;
                    state_nxt   = ISSUE;
                end else if (get_coeffs) begin
                    target_nxt  = 1'b1;
                    n_words_nxt = CO_N;
                    base_nxt    = COEFF_BASE + 32'(layer) * 32'(CSIZE);
                    state_nxt   = ISSUE;
                end
            end
            ISSUE: begin
                if (issued_nxt == n_words)
                    state_nxt = DRAIN;
            end
            default: ;
        endcase

        if (done)
            state_nxt = IDLE;

        read_nxt = (state_nxt == ISSUE) && (issued_nxt < n_words_nxt) && (pend_nxt < PEND_MAX);
        addr_nxt = (state_nxt == ISSUE) ? base_nxt + 32'({issued_nxt, 2'b00}) : avm_address;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            busy        <= 1'b0;
            target      <= 1'b0;
            n_words     <= '0;
            base        <= '0;
            issued      <= '0;
            returned    <= '0;
            pend        <= '0;
            avm_read    <= 1'b0;
            avm_address <= '0;
        end else begin
            state       <= state_nxt;
            busy        <= (state_nxt != IDLE);
            target      <= target_nxt;
            n_words     <= n_words_nxt;
            base        <= base_nxt;
            issued      <= issued_nxt;
            returned    <= returned_nxt;
            pend        <= pend_nxt;
            avm_read    <= read_nxt;
            avm_address <= addr_nxt;
        end
    end

    // Returned words land little-endian in the target array only.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            image_data <= '0;
            coeff_data <= '0;
        end else if (rvalid) begin
            if (target)
                coeff_data[co_idx +: 4] <= avm_readdata;
            else
                image_data[im_idx +: 4] <= avm_readdata;
        end
    end

`ifdef NN_FETCH_CHECKSUM_EN
    logic [15:0] csum_acc, word_sum;

    assign word_sum = 16'(avm_readdata[7:0]) + 16'(avm_readdata[15:8]) +
                      16'(avm_readdata[23:16]) + 16'(avm_readdata[31:24]);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            csum_acc       <= '0;
            checksum       <= '0;
            checksum_valid <= 1'b0;
        end else begin
            checksum_valid <= done;
            if (state == IDLE && (get_image || get_coeffs))
                csum_acc <= '0;
            else if (rvalid)
                csum_acc <= csum_acc + word_sum;
            if (done)
                checksum <= csum_acc + word_sum;
        end
    end
`endif

endmodule

// File: tb/tb_nn_data_fetcher.sv
// Bench for nn_data_fetcher: behavioural Avalon slave with fixed read latency and stall
// injection, address scoreboard, byte-array reference model, one task per scenario.
`timescale 1ns/1ps
module tb_nn_data_fetcher;
    localparam int          IMSIZE     = 64;
    localparam int          CSIZE      = 2048;
    localparam int          LBITS      = 2;
    localparam logic [31:0] IMAGE_BASE = 32'h0000_0000;
    localparam logic [31:0] COEFF_BASE = 32'h0001_0000;
    localparam int          MAX_PEND   = 4;

    // clock / reset and DUT signals
    logic                   clock = 1'b0;
    logic                   reset_n = 1'b0;
    logic                   get_image = 1'b0;
    logic                   get_coeffs = 1'b0;
    logic [LBITS-1:0]       layer = '0;
    logic                   busy;
    logic [IMSIZE-1:0][7:0] image_data;
    logic [CSIZE-1:0][7:0]  coeff_data;
    logic [31:0]            avm_address;
    logic                   avm_read;
    logic                   avm_waitrequest = 1'b0;
    logic [31:0]            avm_readdata = '0;
    logic                   avm_readdatavalid = 1'b0;
    logic [1:0]             fsm_state;
`ifdef NN_FETCH_CHECKSUM_EN
    logic [15:0]            checksum;
    logic                   checksum_valid;
`endif

    nn_data_fetcher #(
        .IMSIZE(IMSIZE), .CSIZE(CSIZE), .LBITS(LBITS),
        .IMAGE_BASE(IMAGE_BASE), .COEFF_BASE(COEFF_BASE), .MAX_PEND(MAX_PEND)
    ) dut (
        .clock(clock), .reset_n(reset_n),
        .get_image(get_image), .get_coeffs(get_coeffs), .layer(layer),
        .busy(busy), .image_data(image_data), .coeff_data(coeff_data),
        .avm_address(avm_address), .avm_read(avm_read),
        .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
        .avm_readdatavalid(avm_readdatavalid),
`ifdef NN_FETCH_CHECKSUM_EN
        .checksum(checksum), .checksum_valid(checksum_valid),
`endif
        .fsm_state(fsm_state)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // scoreboard state
    int          n_checks = 0;
    int          n_pass = 0;
    logic [31:0] exp_q[$];
    logic [31:0] got_q[$];
    logic [IMSIZE-1:0][7:0] exp_img;
    logic [CSIZE-1:0][7:0]  exp_coef;

    // slave model state
    int          lat = 2;
    logic [31:0] salt = '0;
    int          stall_idx = -1;
    int          stall_left = 0;
    bit          stall_active = 0;
    int          stall_seen = 0;
    int          stall_bad = 0;
    int          acc_cnt = 0;
    int          ret_cnt = 0;
    int          max_out = 0;
    int          stale_pulses = 0;
    int          cyc = 0;
    int          due_q[$];
    logic [31:0] dat_q[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a, input logic [31:0] s);
        if (a < COEFF_BASE)
            return ((a >> 2) * 32'h0404_0404 + 32'h0302_0100) ^ s;
        return (a * 32'h9E37_79B1 + 32'h0123_4567) ^ s;
    endfunction

    // Slave drives its outputs at the falling edge; values hold across the next rising edge.
    always @(negedge clock) begin
        cyc++;
        if (!reset_n) begin
            due_q.delete();
            dat_q.delete();
            stall_active      = 0;
            avm_waitrequest   = 1'($urandom_range(0, 1));
            avm_readdatavalid = 1'($urandom_range(0, 1));
            avm_readdata      = $urandom();
        end else begin
            if (stall_left > 0 && (stall_active || (avm_read === 1'b1 && acc_cnt == stall_idx))) begin
                stall_active    = 1;
                avm_waitrequest = 1'b1;
                stall_left--;
                stall_seen++;
                if (avm_read !== 1'b1 || avm_address !== IMAGE_BASE + 32'(4 * stall_idx))
                    stall_bad++;
            end else begin
                stall_active    = 0;
                avm_waitrequest = 1'b0;
            end
            if (avm_read === 1'b1 && !avm_waitrequest) begin
                acc_cnt++;
                got_q.push_back(avm_address);
                due_q.push_back(cyc + lat);
                dat_q.push_back(mem_word(avm_address, salt));
            end
            if (acc_cnt - ret_cnt > max_out)
                max_out = acc_cnt - ret_cnt;
            if (due_q.size() > 0 && due_q[0] == cyc) begin
                void'(due_q.pop_front());
                avm_readdata      = dat_q.pop_front();
                avm_readdatavalid = 1'b1;
                ret_cnt++;
            end else if (stale_pulses > 0) begin
                avm_readdata      = 32'hFFFF_FFFF;
                avm_readdatavalid = 1'b1;
                stale_pulses--;
            end else begin
                avm_readdatavalid = 1'b0;
                avm_readdata      = $urandom();
            end
        end
    end

    // driver tasks
    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    task automatic start_fetch(input bit img, input bit cf, input logic [LBITS-1:0] lyr);
        got_q.delete();
        acc_cnt    = 0;
        ret_cnt    = 0;
        max_out    = 0;
        stall_seen = 0;
        stall_bad  = 0;
        get_image  = img;
        get_coeffs = cf;
        layer      = lyr;
        tick();
        get_image  = 1'b0;
        get_coeffs = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output int busy_cycles, output bit timed_out);
        busy_cycles = 0;
        timed_out   = 1;
        for (int i = 0; i < budget; i++) begin
            if (busy !== 1'b1) begin
                timed_out = 0;
                break;
            end
            busy_cycles++;
            tick();
        end
    endtask

    task automatic build_exp_img(input logic [31:0] s);
        for (int k = 0; k < IMSIZE / 4; k++)
            exp_img[4*k +: 4] = mem_word(IMAGE_BASE + 32'(4 * k), s);
    endtask

    task automatic push_exp_addrs(input logic [31:0] b, input int n);
        exp_q.delete();
        for (int k = 0; k < n; k++)
            exp_q.push_back(b + 32'(4 * k));
    endtask

    // scenarios
    task automatic test_reset();
        int bad;
        reset_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            get_image  = 1'($urandom_range(0, 1));
            get_coeffs = 1'($urandom_range(0, 1));
            layer      = LBITS'($urandom_range(0, 3));
            tick();
        end
        n_checks++;
        if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else n_pass++;
        n_checks++;
        if (avm_read !== 1'b0) $display("FAIL reset_read: got %b expected 0", avm_read); else n_pass++;
        n_checks++;
        if (avm_address !== 32'h0) $display("FAIL reset_addr: got %h expected 0", avm_address); else n_pass++;
        n_checks++;
        if (fsm_state !== 2'd0) $display("FAIL reset_state: got %0d expected 0", fsm_state); else n_pass++;
        bad = 0;
        for (int i = 0; i < IMSIZE; i++) if (image_data[i] !== 8'h00) bad++;
        n_checks++;
        if (bad != 0) $display("FAIL reset_image: %0d nonzero bytes, expected 0", bad); else n_pass++;
        bad = 0;
        for (int i = 0; i < CSIZE; i++) if (coeff_data[i] !== 8'h00) bad++;
        n_checks++;
        if (bad != 0) $display("FAIL reset_coeff: %0d nonzero bytes, expected 0", bad); else n_pass++;
        get_image  = 1'b0;
        get_coeffs = 1'b0;
        reset_n    = 1'b1;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (busy !== 1'b0 || avm_read !== 1'b0) bad++;
        end
        n_checks++;
        if (bad != 0) $display("FAIL reset_stays_idle: %0d active cycles, expected 0", bad); else n_pass++;
    endtask

    task automatic test_image_fetch();
        int nb, bad, first;
        bit to;
        logic [31:0] e, g;
        lat  = 2;
        salt = 32'h0;
        push_exp_addrs(IMAGE_BASE, IMSIZE / 4);
        start_fetch(1'b1, 1'b0, '0);
        wait_idle(200, nb, to);
        n_checks++;
        if (to) $display("FAIL image_timeout: busy still %b after 200 cycles", busy); else n_pass++;
        n_checks++;
        if (nb != IMSIZE / 4 + 2) $display("FAIL image_busy_len: got %0d expected %0d", nb, IMSIZE / 4 + 2); else n_pass++;
`ifdef NN_FETCH_CHECKSUM_EN
        n_checks++;
        if (checksum_valid !== 1'b1 || checksum !== 16'd2016)
            $display("FAIL image_checksum: got %b/%0d expected 1/2016", checksum_valid, checksum);
        else n_pass++;
`endif
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = (got_q.size() > 0) ? got_q.pop_front() : 32'hXXXX_XXXX;
            n_checks++;
            if (g !== e) $display("FAIL image_addr: got %h expected %h", g, e); else n_pass++;
        end
        n_checks++;
        if (got_q.size() != 0) $display("FAIL image_extra_reads: got %0d expected 0", got_q.size()); else n_pass++;
        bad = 0; first = -1;
        for (int i = 0; i < IMSIZE; i++) if (image_data[i] !== 8'(i)) begin bad++; if (first < 0) first = i; end
        n_checks++;
        if (bad != 0) $display("FAIL image_data: %0d bad bytes, first at %0d got %h expected %h",
                               bad, first, image_data[first], 8'(first));
        else n_pass++;
        bad = 0;
        for (int i = 0; i < CSIZE; i++) if (coeff_data[i] !== 8'h00) bad++;
        n_checks++;
        if (bad != 0) $display("FAIL image_coeff_untouched: %0d changed bytes, expected 0", bad); else n_pass++;
        for (int i = 0; i < IMSIZE; i++) exp_img[i] = 8'(i);
    endtask

    task automatic test_coeff_fetch();
        int nb, bad, first;
        bit to;
        logic [31:0] e, g;
        lat  = 3;
        salt = 32'hC0FF_EE00;
        push_exp_addrs(32'h0001_1000, CSIZE / 4);
        for (int k = 0; k < CSIZE / 4; k++)
            exp_coef[4*k +: 4] = mem_word(32'h0001_1000 + 32'(4 * k), salt);
        n_checks++;
        if (exp_q[CSIZE/4-1] !== 32'h0001_17FC) $display("FAIL coeff_last_addr_model: got %h expected 117fc", exp_q[CSIZE/4-1]); else n_pass++;
        start_fetch(1'b0, 1'b1, 2'd2);
        wait_idle(2000, nb, to);
        n_checks++;
        if (to) $display("FAIL coeff_timeout: busy still %b after 2000 cycles", busy); else n_pass++;
        n_checks++;
        if (nb != CSIZE / 4 + 3) $display("FAIL coeff_busy_len: got %0d expected %0d", nb, CSIZE / 4 + 3); else n_pass++;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = (got_q.size() > 0) ? got_q.pop_front() : 32'hXXXX_XXXX;
            n_checks++;
            if (g !== e) $display("FAIL coeff_addr: got %h expected %h", g, e); else n_pass++;
        end
        n_checks++;
        if (got_q.size() != 0) $display("FAIL coeff_extra_reads: got %0d expected 0", got_q.size()); else n_pass++;
        bad = 0; first = -1;
        for (int i = 0; i < CSIZE; i++) if (coeff_data[i] !== exp_coef[i]) begin bad++; if (first < 0) first = i; end
        n_checks++;
        if (bad != 0) $display("FAIL coeff_data: %0d bad bytes, first at %0d got %h expected %h",
                               bad, first, coeff_data[first], exp_coef[first]);
        else n_pass++;
        bad = 0;
        for (int i = 0; i < IMSIZE; i++) if (image_data[i] !== exp_img[i]) bad++;
        n_checks++;
        if (bad != 0) $display("FAIL coeff_image_untouched: %0d changed bytes, expected 0", bad); else n_pass++;
    endtask

    task automatic test_stall();
        int nb, bad, first;
        bit to;
        logic [31:0] e, g;
        lat        = 8;
        salt       = 32'h1357_9BDF;
        stall_idx  = 3;
        stall_left = 5;
        build_exp_img(salt);
        push_exp_addrs(IMAGE_BASE, IMSIZE / 4);
        start_fetch(1'b1, 1'b0, '0);
        wait_idle(400, nb, to);
        stall_idx = -1;
        n_checks++;
        if (to) $display("FAIL stall_timeout: busy still %b after 400 cycles", busy); else n_pass++;
        n_checks++;
        if (stall_seen != 5) $display("FAIL stall_cycles: got %0d expected 5", stall_seen); else n_pass++;
        n_checks++;
        if (stall_bad != 0) $display("FAIL stall_hold: %0d unstable cycles, expected 0", stall_bad); else n_pass++;
        n_checks++;
        if (max_out != MAX_PEND) $display("FAIL stall_max_pend: got %0d expected %0d", max_out, MAX_PEND); else n_pass++;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = (got_q.size() > 0) ? got_q.pop_front() : 32'hXXXX_XXXX;
            n_checks++;
            if (g !== e) $display("FAIL stall_addr: got %h expected %h", g, e); else n_pass++;
        end
        bad = 0; first = -1;
        for (int i = 0; i < IMSIZE; i++) if (image_data[i] !== exp_img[i]) begin bad++; if (first < 0) first = i; end
        n_checks++;
        if (bad != 0) $display("FAIL stall_data: %0d bad bytes, first at %0d got %h expected %h",
                               bad, first, image_data[first], exp_img[first]);
        else n_pass++;
        bad = 0;
        for (int i = 0; i < CSIZE; i++) if (coeff_data[i] !== exp_coef[i]) bad++;
        n_checks++;
        if (bad != 0) $display("FAIL stall_coeff_untouched: %0d changed bytes, expected 0", bad); else n_pass++;
    endtask

    task automatic test_simultaneous();
        int nb, bad, first;
        bit to;
        logic [31:0] e, g;
        lat  = 2;
        salt = 32'h5A5A_5A5A;
        build_exp_img(salt);
        push_exp_addrs(IMAGE_BASE, IMSIZE / 4);
        start_fetch(1'b1, 1'b1, 2'd1);
        for (int i = 0; i < 3; i++) tick();
        get_coeffs = 1'b1;
        layer      = 2'd0;
        tick();
        get_coeffs = 1'b0;
        wait_idle(200, nb, to);
        n_checks++;
        if (to) $display("FAIL simul_timeout: busy still %b after 200 cycles", busy); else n_pass++;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (busy !== 1'b0 || avm_read !== 1'b0) bad++;
        end
        n_checks++;
        if (bad != 0) $display("FAIL simul_no_second_fetch: %0d active cycles, expected 0", bad); else n_pass++;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = (got_q.size() > 0) ? got_q.pop_front() : 32'hXXXX_XXXX;
            n_checks++;
            if (g !== e) $display("FAIL simul_addr: got %h expected %h", g, e); else n_pass++;
        end
        n_checks++;
        if (got_q.size() != 0) $display("FAIL simul_extra_reads: got %0d expected 0", got_q.size()); else n_pass++;
        bad = 0; first = -1;
        for (int i = 0; i < IMSIZE; i++) if (image_data[i] !== exp_img[i]) begin bad++; if (first < 0) first = i; end
        n_checks++;
        if (bad != 0) $display("FAIL simul_image: %0d bad bytes, first at %0d got %h expected %h",
                               bad, first, image_data[first], exp_img[first]);
        else n_pass++;
        bad = 0;
        for (int i = 0; i < CSIZE; i++) if (coeff_data[i] !== exp_coef[i]) bad++;
        n_checks++;
        if (bad != 0) $display("FAIL simul_coeff_untouched: %0d changed bytes, expected 0", bad); else n_pass++;
    endtask

    task automatic test_reset_mid_fetch();
        int nb, bad, first;
        bit to;
        logic [31:0] e, g;
        lat  = 2;
        salt = 32'h0;
        start_fetch(1'b1, 1'b0, '0);
        to = 1;
        for (int i = 0; i < 100; i++) begin
            if (ret_cnt >= 7) begin to = 0; break; end
            tick();
        end
        n_checks++;
        if (to) $display("FAIL midrst_progress: returned %0d expected 7", ret_cnt); else n_pass++;
        reset_n = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        n_checks++;
        if (busy !== 1'b0 || avm_read !== 1'b0 || avm_address !== 32'h0)
            $display("FAIL midrst_outputs: got busy=%b read=%b addr=%h expected 0/0/0", busy, avm_read, avm_address);
        else n_pass++;
        bad = 0;
        for (int i = 0; i < IMSIZE; i++) if (image_data[i] !== 8'h00) bad++;
        for (int i = 0; i < CSIZE; i++) if (coeff_data[i] !== 8'h00) bad++;
        n_checks++;
        if (bad != 0) $display("FAIL midrst_arrays: %0d nonzero bytes, expected 0", bad); else n_pass++;
        get_image  = 1'b0;
        get_coeffs = 1'b0;
        reset_n    = 1'b1;
        tick();
        got_q.delete();
        stale_pulses = 3;
        for (int i = 0; i < 5; i++) tick();
        bad = 0;
        for (int i = 0; i < IMSIZE; i++) if (image_data[i] !== 8'h00) bad++;
        n_checks++;
        if (bad != 0) $display("FAIL stale_written: %0d nonzero bytes, expected 0", bad); else n_pass++;
        n_checks++;
        if (busy !== 1'b0 || got_q.size() != 0)
            $display("FAIL stale_activity: got busy=%b reads=%0d expected 0/0", busy, got_q.size());
        else n_pass++;
        salt = 32'h0F0F_0F0F;
        build_exp_img(salt);
        push_exp_addrs(IMAGE_BASE, IMSIZE / 4);
        start_fetch(1'b1, 1'b0, '0);
        wait_idle(200, nb, to);
        n_checks++;
        if (to || nb != IMSIZE / 4 + 2)
            $display("FAIL refetch_busy_len: got %0d (timeout %b) expected %0d", nb, to, IMSIZE / 4 + 2);
        else n_pass++;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = (got_q.size() > 0) ? got_q.pop_front() : 32'hXXXX_XXXX;
            n_checks++;
            if (g !== e) $display("FAIL refetch_addr: got %h expected %h", g, e); else n_pass++;
        end
        bad = 0; first = -1;
        for (int i = 0; i < IMSIZE; i++) if (image_data[i] !== exp_img[i]) begin bad++; if (first < 0) first = i; end
        n_checks++;
        if (bad != 0) $display("FAIL refetch_data: %0d bad bytes, first at %0d got %h expected %h",
                               bad, first, image_data[first], exp_img[first]);
        else n_pass++;
        bad = 0;
        for (int i = 0; i < CSIZE; i++) if (coeff_data[i] !== 8'h00) bad++;
        n_checks++;
        if (bad != 0) $display("FAIL refetch_coeff_untouched: %0d nonzero bytes, expected 0", bad); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_image_fetch();
        test_coeff_fetch();
        test_stall();
        test_simultaneous();
        test_reset_mid_fetch();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
